// File: rtl/log_spawn_sched.sv
// Log spawn scheduler: rotating-priority arbitration of per-lane spawn requests with per-lane
// frame cooldowns and a wrapping offset-table index. Optional macro LOG_SPAWN_JITTER_EN adds frame-count X jitter.
module log_spawn_sched #(
    parameter int NUM_LANES       = 4,
    parameter int NUM_LOGS        = 100,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic                       CLK,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic [NUM_LANES-1:0]       spawn_req,
    input  logic [NUM_LOGS-1:0][8:0]   start_offsetX,
    input  logic [NUM_LOGS-1:0][8:0]   start_offsetY,
    input  logic                       spawn_ack,
    output logic                       spawn_valid,
    output logic [NUM_LANES-1:0]       spawn_grant,
    output logic [8:0]                 spawn_x,
    output logic [8:0]                 spawn_y,
    output logic [6:0]                 log_index,
    output logic [1:0]                 dbg_state
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_LANES-1:0] elig;
    logic [NUM_LANES-1:0] elig_q, elig_d;
    logic [3:0]           cool_q [NUM_LANES];
    logic [3:0]           cool_d [NUM_LANES];
    logic [LW-1:0]        rr_q, rr_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [LW-1:0]        win_lane;
    logic [LW-1:0]        cand;
    logic                 found;
    logic [6:0]           idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic [NUM_LANES-1:0] grant_q, grant_d;
    logic [8:0]           x_q, x_d;
    logic [8:0]           y_q, y_d;
    logic [6:0]           logidx_q, logidx_d;
    logic                 ack_fire;
    logic [8:0]           jitter;

`ifdef LOG_SPAWN_JITTER_EN
    logic [8:0] frame_cnt_q;

    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            frame_cnt_q <= '0;
        end else if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_q + 9'd1;
        end
    end

    assign jitter = frame_cnt_q;
`else
    assign jitter = '0;
`endif

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            elig[i] = spawn_req[i] && (cool_q[i] == 4'd0);
        end
    end

    // The eligible set is frozen on leaving IDLE so a request dropped during GRANT cannot empty the arbitration.
    always_comb begin
        win_lane = rr_q;
        found    = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = LW'((int'(rr_q) + k) % NUM_LANES);
            if (!found && elig_q[cand]) begin
                found    = 1'b1;
                win_lane = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        elig_d   = elig_q;
        rr_d     = rr_q;
        lane_d   = lane_q;
        idx_d    = idx_q;
        valid_d  = valid_q;
        grant_d  = grant_q;
        x_d      = x_q;
        y_d      = y_q;
        logidx_d = logidx_q;
        ack_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    state_d = GRANT;
                    elig_d  = elig;
                end
            end
            GRANT: begin
                state_d           = ISSUE;
                lane_d            = win_lane;
                valid_d           = 1'b1;
                grant_d           = '0;
                grant_d[win_lane] = 1'b1;
                x_d               = start_offsetX[idx_q] ^ jitter;
                y_d               = start_offsetY[idx_q];
                logidx_d          = idx_q;
            end
            ISSUE: begin
                if (spawn_ack) begin
                    ack_fire = 1'b1;
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                    grant_d  = '0;
                    idx_d    = (idx_q == 7'(NUM_LOGS - 1)) ? 7'd0 : idx_q + 7'd1;
                    rr_d     = (lane_q == LW'(NUM_LANES - 1)) ? '0 : lane_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A cooldown load on ack takes precedence over a coincident frame decrement.
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            cool_d[i] = cool_q[i];
            if (ack_fire && (lane_q == LW'(i))) begin
                cool_d[i] = 4'(COOLDOWN_FRAMES);
            end else if (startOfFrame && (cool_q[i] != 4'd0)) begin
                cool_d[i] = cool_q[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge CLK or negedge resetN) begin
        if (!resetN) begin
            elig_q   <= '0;
            rr_q     <= '0;
            lane_q   <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            grant_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            logidx_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                cool_q[i] <= 4'd0;
            end
        end else begin
            elig_q   <= elig_d;
            rr_q     <= rr_d;
            lane_q   <= lane_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            grant_q  <= grant_d;
            x_q      <= x_d;
            y_q      <= y_d;
            logidx_q <= logidx_d;
            for (int i = 0; i < NUM_LANES; i++) begin
                cool_q[i] <= cool_d[i];
            end
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_grant = grant_q;
    assign spawn_x     = x_q;
    assign spawn_y     = y_q;
    assign log_index   = logidx_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_log_spawn_sched.sv
// Directed bench for log_spawn_sched: latency, hold, cooldown, rotation, reset and index wrap.
// Handshake: a spawn is transferred on a rising edge where spawn_valid and spawn_ack are both high.
module tb_log_spawn_sched;

    logic              CLK;
    logic              resetN;
    logic              startOfFrame;
    logic [3:0]        spawn_req;
    logic [99:0][8:0]  tabx;
    logic [99:0][8:0]  taby;
    logic              spawn_ack;
    logic              spawn_valid;
    logic [3:0]        spawn_grant;
    logic [8:0]        spawn_x;
    logic [8:0]        spawn_y;
    logic [6:0]        log_index;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int fc = 0;
    int fc_prev = 0;

    log_spawn_sched #(
        .NUM_LANES(4),
        .NUM_LOGS(100),
        .COOLDOWN_FRAMES(8)
    ) dut (
        .CLK(CLK),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .spawn_req(spawn_req),
        .start_offsetX(tabx),
        .start_offsetY(taby),
        .spawn_ack(spawn_ack),
        .spawn_valid(spawn_valid),
        .spawn_grant(spawn_grant),
        .spawn_x(spawn_x),
        .spawn_y(spawn_y),
        .log_index(log_index),
        .dbg_state(dbg_state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame model: fc_prev is the count just before the latest edge.
    task automatic tick();
        @(posedge CLK);
        fc_prev = fc;
        if (startOfFrame && resetN) fc = (fc + 1) % 512;
        #1;
    endtask

    function automatic logic [8:0] ex(input int i, input int f);
`ifdef LOG_SPAWN_JITTER_EN
        return tabx[i] ^ 9'(f);
`else
        return tabx[i] ^ 9'(0 * f);
`endif
    endfunction

    task automatic spawn(input logic [3:0] eg, input int ei, input string tag);
        int n = 0;
        while (spawn_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 20), 32'd1);
        chk({tag, "_grant"}, 32'(spawn_grant), 32'(eg));
        chk({tag, "_idx"}, 32'(log_index), 32'(ei));
        chk({tag, "_x"}, 32'(spawn_x), 32'(ex(ei, fc_prev)));
        chk({tag, "_y"}, 32'(spawn_y), 32'(taby[ei]));
        spawn_ack = 1'b1;
        tick();
        spawn_ack = 1'b0;
        chk({tag, "_drop"}, 32'(spawn_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 100; i++) begin
            tabx[i] = 9'((i * 37 + 5) % 512);
            taby[i] = 9'((i * 91 + 300) % 512);
        end
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        spawn_req    = 4'b0000;
        spawn_ack    = 1'b0;
        #1;
        chk("rst_valid", 32'(spawn_valid), 32'd0);
        chk("rst_grant", 32'(spawn_grant), 32'd0);
        chk("rst_x", 32'(spawn_x), 32'd0);
        chk("rst_idx", 32'(log_index), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        tick();
        tick();
        resetN = 1'b1;

        // Stray ack while idle must change nothing.
        spawn_ack = 1'b1;
        tick();
        tick();
        spawn_ack = 1'b0;
        chk("idle_ack_state", 32'(dbg_state), 32'd0);
        chk("idle_ack_valid", 32'(spawn_valid), 32'd0);

        startOfFrame = 1'b1;
        repeat (3) tick();
        startOfFrame = 1'b0;

        // Single request, exact two-cycle latency.
        spawn_req = 4'b0001;
        tick();
        chk("lat_c1_valid", 32'(spawn_valid), 32'd0);
        chk("lat_c1_state", 32'(dbg_state), 32'd1);
        tick();
        chk("lat_c2_valid", 32'(spawn_valid), 32'd1);
        chk("lat_c2_grant", 32'(spawn_grant), 32'h1);
        chk("lat_c2_idx", 32'(log_index), 32'd0);
        chk("lat_c2_x", 32'(spawn_x), 32'(ex(0, 3)));
        chk("lat_c2_y", 32'(spawn_y), 32'(taby[0]));
        spawn_req = 4'b0000;
        spawn_ack = 1'b1;
        tick();
        spawn_ack = 1'b0;
        chk("ack_valid", 32'(spawn_valid), 32'd0);
        chk("ack_grant", 32'(spawn_grant), 32'd0);
        chk("ack_state", 32'(dbg_state), 32'd0);

        // Hold with ack withheld; request dropped after grant.
        spawn_req = 4'b0100;
        tick();
        tick();
        spawn_req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", 32'(spawn_valid), 32'd1);
            chk("hold_grant", 32'(spawn_grant), 32'h4);
            chk("hold_idx", 32'(log_index), 32'd1);
            chk("hold_x", 32'(spawn_x), 32'(ex(1, 3)));
            chk("hold_y", 32'(spawn_y), 32'(taby[1]));
            tick();
        end
        spawn_ack = 1'b1;
        tick();
        spawn_ack = 1'b0;
        chk("hold_done", 32'(spawn_valid), 32'd0);

        // Lane 2 cooldown: blocked through 7 frames, eligible after the 8th.
        spawn_req    = 4'b0100;
        startOfFrame = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            chk("cool_blocked", 32'(dbg_state), 32'd0);
        end
        tick();
        chk("cool_8th", 32'(dbg_state), 32'd0);
        startOfFrame = 1'b0;
        tick();
        chk("cool_grant_state", 32'(dbg_state), 32'd1);
        tick();
        chk("cool_valid", 32'(spawn_valid), 32'd1);
        chk("cool_grant", 32'(spawn_grant), 32'h4);
        chk("cool_idx", 32'(log_index), 32'd2);
        chk("cool_x", 32'(spawn_x), 32'(ex(2, 11)));
        spawn_ack = 1'b1;
        tick();
        spawn_ack = 1'b0;

        // Reset while issuing drops valid immediately.
        spawn_req = 4'b0001;
        tick();
        tick();
        chk("pre_rst_valid", 32'(spawn_valid), 32'd1);
        chk("pre_rst_idx", 32'(log_index), 32'd3);
        resetN = 1'b0;
        fc     = 0;
        #1;
        chk("mid_rst_valid", 32'(spawn_valid), 32'd0);
        chk("mid_rst_grant", 32'(spawn_grant), 32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        tick();
        resetN = 1'b1;

        // Contention: rotation then wrap back to lane 0 after cooldown.
        spawn_req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            spawn(4'(1 << k), k, "cont");
        end
        startOfFrame = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("cont_cool", 32'(spawn_valid), 32'd0);
        end
        startOfFrame = 1'b0;
        spawn(4'b0001, 4, "cont_again");

        // Index wrap: 100 spawns since reset, then index 0 again.
        startOfFrame = 1'b1;
        for (int k = 5; k < 100; k++) begin
            spawn(4'(1 << (k % 4)), k, "wrap");
        end
        spawn(4'b0001, 0, "wrap_101");
        startOfFrame = 1'b0;
        spawn_req    = 4'b0000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
